// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer types, response codes and the slave controller FSM states.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } state_t;

    localparam int unsigned WaitCntW = 3;

    // Only byte reads of the four registers at haddr[3:2] == 0 are supported.
    function automatic logic is_err_xfer(input logic       write,
                                         input logic [2:0] size,
                                         input logic [3:0] addr);
        return write || (size != 3'd0) || (addr[3:2] != 2'd0);
    endfunction

endpackage

// File: rtl/ahb_wait_counter.sv
// Data-phase wait-state counter: loadable down-counter with a flag on its final wait cycle.
module ahb_wait_counter #(
    parameter int unsigned Width = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             last_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == Width'(1));

endmodule

// File: rtl/ahb_slave_ctrl.sv
// AHB-Lite slave control path for a four-register read-only block: wait states,
// two-cycle ERROR responses and a saturating error counter.
module ahb_slave_ctrl
    import ahb_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic       hclk,
    input  logic       hreset_n,
    input  logic       hsel_x,
    input  logic       hready,
    input  logic [1:0] htrans,
    input  logic       hwrite,
    input  logic [3:0] haddr,
    input  logic [2:0] hsize,
    output logic       hreadyout,
    output logic       hresp,
    output logic [1:0] read_select,
    output logic       rd_en,
    output logic [7:0] err_count
);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] err_q, err_d;
    htrans_t    trans_type;
    logic       addr_phase_ok;
    logic       accept;
    logic       xfer_err;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_last;

    assign trans_type = htrans_t'(htrans);

    // Address phases are only taken while this slave is driving hreadyout high.
    assign addr_phase_ok = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
    assign accept        = addr_phase_ok && hsel_x && hready &&
                           ((trans_type == HTRANS_NONSEQ) || (trans_type == HTRANS_SEQ));
    assign xfer_err      = is_err_xfer(hwrite, hsize, haddr);

    ahb_wait_counter #(
        .Width (WaitCntW)
    ) u_wait_counter (
        .clk_i      (hclk),
        .rst_ni     (hreset_n),
        .load_i     (cnt_load),
        .load_val_i (WaitCntW'(WAIT_STATES)),
        .dec_i      (cnt_dec),
        .last_o     (cnt_last)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            StWait: begin
                cnt_dec = 1'b1;
                if (cnt_last) begin
                    state_d = StData;
                end
            end
            StErr1: begin
                state_d = StErr2;
            end
            default: begin
                state_d = StIdle;
                if (accept) begin
                    if (xfer_err) begin
                        state_d = StErr1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = StData;
                    end else begin
                        state_d  = StWait;
                        cnt_load = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        sel_d = sel_q;
        err_d = err_q;
        if (accept) begin
            sel_d = haddr[1:0];
        end
        if (accept && xfer_err && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q <= StIdle;
            sel_q   <= 2'd0;
            err_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    assign hreadyout   = !((state_q == StWait) || (state_q == StErr1));
    assign hresp       = ((state_q == StErr1) || (state_q == StErr2)) ? HRESP_ERROR : HRESP_OKAY;
    assign rd_en       = (state_q == StData);
    assign read_select = sel_q;
    assign err_count   = err_q;

endmodule
